seq_multiplier: RTL and testbench

Parametrised sequential shift-and-add multiplier that computes the full-width product of two WIDTH-bit operands, in either unsigned or two's-complement signed mode. It trades the area of a combinational partial-product array for a latency of WIDTH cycles, using one WIDTH-bit adder plus a small FSM. Operands enter through a start/busy/done handshake. It is the datapath arithmetic unit for lab designs that need wider or signed products.

---
 rtl/seq_multiplier.sv | 97 +++++++++
 tb/tb_seq_multiplier.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH-cycle latency, full 2*WIDTH-bit product,
// unsigned or two's-complement signed operands via a start/busy/done handshake.
module seq_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFinish
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CntW-1:0]    cnt_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_in;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_final;

    // The multiplier magnitude is parked in the accumulator's low half; each step consumes
    // its LSB while product bits shift in from above, so no separate multiplier register.
    always_comb begin
        a_mag      = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag      = (signed_mode && b[WIDTH-1]) ? -b : b;
        neg_in     = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        upper_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step   = {upper_sum, acc_q[WIDTH-1:1]};
        prod_final = neg_q ? -acc_step : acc_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            p       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_q <= a_mag;
                        neg_q   <= neg_in;
                        acc_q   <= {{WIDTH{1'b0}}, b_mag};
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CntOne;
                    if (cnt_q == CntLast) begin
                        p       <= prod_final;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised self-checking bench for seq_multiplier at WIDTH=8 and WIDTH=4, checked
// against an integer-arithmetic reference model.
module tb_seq_multiplier;

    logic        clk;
    logic        rst;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        start4, sm4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    int n_checks = 0;
    int n_pass   = 0;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .signed_mode (sm8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .p           (p8)
    );

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .start       (start4),
        .signed_mode (sm4),
        .a           (a4),
        .b           (b4),
        .busy        (busy4),
        .done        (done4),
        .p           (p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y,
                                           input logic sm);
        longint xv, yv;
        logic [63:0] pv;
        xv = sm ? longint'($signed(x)) : longint'(x);
        yv = sm ? longint'($signed(y)) : longint'(y);
        pv = 64'(xv * yv);
        return pv[15:0];
    endfunction

    function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y,
                                          input logic sm);
        longint xv, yv;
        logic [63:0] pv;
        xv = sm ? longint'($signed(x)) : longint'(x);
        yv = sm ? longint'($signed(y)) : longint'(y);
        pv = 64'(xv * yv);
        return pv[7:0];
    endfunction

    // Starts an op one cycle ahead of the accept edge, returns the product, the cycles
    // from accept to done (-1 on timeout), busy-high samples, and done one cycle later.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic sm,
                        output logic [15:0] pr, output int lat, output int busy_cnt,
                        output logic done_after);
        bit got = 0;
        a8 = ia; b8 = ib; sm8 = sm; start8 = 1'b1;
        @(posedge clk); #1;
        start8   = 1'b0;
        busy_cnt = busy8 ? 1 : 0;
        lat      = 0;
        pr       = 'x;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (busy8) busy_cnt++;
            if (done8) begin
                pr  = p8;
                got = 1;
                break;
            end
        end
        if (!got) lat = -1;
        @(posedge clk); #1;
        done_after = done8;
    endtask

    task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic sm,
                        output logic [7:0] pr, output int lat);
        bit got = 0;
        a4 = ia; b4 = ib; sm4 = sm; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat    = 0;
        pr     = 'x;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done4) begin
                pr  = p4;
                got = 1;
                break;
            end
        end
        if (!got) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy8, done8, p8} !== 18'd0) $display("FAIL reset8: got %h expected 0", {busy8, done8, p8});
        else n_pass++;
        n_checks++;
        if ({busy4, done4, p4} !== 10'd0) $display("FAIL reset4: got %h expected 0", {busy4, done4, p4});
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_max();
        logic [15:0] pr; int lat, bc; logic da;
        run8(8'd255, 8'd255, 1'b0, pr, lat, bc, da);
        n_checks++;
        if (pr !== 16'hFE01) $display("FAIL umax_p: got %h expected fe01", pr); else n_pass++;
        n_checks++;
        if (lat != 8) $display("FAIL umax_latency: got %0d expected 8", lat); else n_pass++;
        n_checks++;
        if (bc != 8) $display("FAIL umax_busy_cycles: got %0d expected 8", bc); else n_pass++;
        n_checks++;
        if (da !== 1'b0) $display("FAIL umax_done_pulse: got %b expected 0", da); else n_pass++;
    endtask

    task automatic test_signed_corners();
        logic [7:0]  ta [4] = '{8'h80, 8'h80, 8'hFF, 8'hFF};
        logic [7:0]  tb [4] = '{8'h80, 8'h7F, 8'hFF, 8'h01};
        logic [15:0] te [4] = '{16'h4000, 16'hC080, 16'h0001, 16'hFFFF};
        logic [15:0] pr; int lat, bc; logic da;
        for (int i = 0; i < 4; i++) begin
            run8(ta[i], tb[i], 1'b1, pr, lat, bc, da);
            n_checks++;
            if (pr !== te[i] || lat != 8)
                $display("FAIL signed_corner%0d: got p=%h lat=%0d expected p=%h lat=8",
                         i, pr, lat, te[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random8();
        logic [15:0] pr; int lat, bc; logic da;
        logic [7:0] x, y; logic sm;
        for (int i = 0; i < 60; i++) begin
            x  = 8'($urandom);
            y  = 8'($urandom);
            sm = 1'($urandom);
            run8(x, y, sm, pr, lat, bc, da);
            n_checks++;
            if (pr !== model8(x, y, sm) || lat != 8)
                $display("FAIL random8: a=%h b=%h sm=%b got p=%h lat=%0d expected p=%h lat=8",
                         x, y, sm, pr, lat, model8(x, y, sm));
            else n_pass++;
        end
    endtask

    task automatic test_exhaustive4();
        logic [7:0] pr; int lat;
        run4(4'd15, 4'd15, 1'b0, pr, lat);
        n_checks++;
        if (pr !== 8'hE1) $display("FAIL w4_u15x15: got %h expected e1", pr); else n_pass++;
        run4(4'h8, 4'd7, 1'b1, pr, lat);
        n_checks++;
        if (pr !== 8'hC8) $display("FAIL w4_sm8x7: got %h expected c8", pr); else n_pass++;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    run4(4'(i), 4'(j), 1'(s), pr, lat);
                    n_checks++;
                    if (pr !== model4(4'(i), 4'(j), 1'(s)) || lat != 4)
                        $display("FAIL w4_sweep: a=%0d b=%0d sm=%0d got p=%h lat=%0d expected p=%h lat=4",
                                 i, j, s, pr, lat, model4(4'(i), 4'(j), 1'(s)));
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        bit got = 0;
        logic [15:0] pr = 'x;
        int busy_seen = 0;
        a8 = 8'd10; b8 = 8'd20; sm8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'd99; b8 = 8'd77; sm8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start8 = 1'b1; a8 = 8'hC3; b8 = 8'h5A;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'd3; b8 = 8'd5;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            a8 = 8'($urandom);
            if (done8) begin
                pr  = p8;
                got = 1;
                break;
            end
        end
        n_checks++;
        if (!got || pr !== 16'd200)
            $display("FAIL ignore_start: got done=%0d p=%h expected done=1 p=00c8", got, pr);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy8) busy_seen++;
        end
        n_checks++;
        if (busy_seen != 0) $display("FAIL start_not_queued: got %0d busy cycles expected 0", busy_seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        logic [15:0] exp;
        exp = model8(8'd25, 8'hFD, 1'b1);
        a8 = 8'd25; b8 = 8'hFD; sm8 = 1'b1; start8 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                done_at.push_back(k);
                n_checks++;
                if (p8 !== exp) $display("FAIL b2b_p: got %h expected %h", p8, exp);
                else n_pass++;
            end
        end
        start8 = 1'b0;
        n_checks++;
        if (done_at.size() != 4) $display("FAIL b2b_count: got %0d expected 4", done_at.size());
        else n_pass++;
        if (done_at.size() > 0) begin
            n_checks++;
            if (done_at[0] != 9) $display("FAIL b2b_first: got %0d expected 9", done_at[0]);
            else n_pass++;
        end
        for (int i = 1; i < done_at.size(); i++) begin
            n_checks++;
            if (done_at[i] - done_at[i-1] != 10)
                $display("FAIL b2b_spacing: got %0d expected 10", done_at[i] - done_at[i-1]);
            else n_pass++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        logic [15:0] pr; int lat, bc; logic da;
        a8 = 8'd12; b8 = 8'd13; sm8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy8, done8, p8} !== 18'd0)
            $display("FAIL reset_mid_async: got busy=%b done=%b p=%h expected all 0", busy8, done8, p8);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) dones++;
        end
        n_checks++;
        if (dones != 0) $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", dones);
        else n_pass++;
        run8(8'd7, 8'd6, 1'b0, pr, lat, bc, da);
        n_checks++;
        if (pr !== 16'd42 || lat != 8)
            $display("FAIL after_reset: got p=%h lat=%0d expected p=002a lat=8", pr, lat);
        else n_pass++;
    endtask

    task automatic test_zero_hold();
        logic [15:0] pr; int lat, bc; logic da;
        run8(8'd0, 8'd200, 1'b0, pr, lat, bc, da);
        n_checks++;
        if (pr !== 16'd0 || lat != 8)
            $display("FAIL zero_op: got p=%h lat=%0d expected p=0000 lat=8", pr, lat);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (p8 !== 16'd0 || done8 !== 1'b0 || busy8 !== 1'b0)
                $display("FAIL zero_hold: got p=%h done=%b busy=%b expected 0/0/0", p8, done8, busy8);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_corners();
        test_random8();
        test_exhaustive4();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_zero_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
